// File: rtl/product_bcd_converter_pkg.sv
// Shared types and default sizing for the signed-product to BCD converter.
// The bench imports the same constants so both sides agree on widths.
package product_bcd_converter_pkg;

    localparam int PBC_WIDTH  = 16;
    localparam int PBC_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd_state_t;

endpackage

// File: rtl/product_bcd_converter_bcd_add3.sv
// One double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    // Add-3 correction for a single working digit
    always_comb begin
        q = d;
        if (d >= 4'd5) begin
            q = d + 4'd3;
        end else begin
            q = d;
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential two's-complement to sign + BCD converter, one shift per clock.
// Results (bcd/neg) only change on the final shift, so the display never flickers.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int WIDTH  = PBC_WIDTH,
    parameter int DIGITS = PBC_DIGITS
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      product,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int            BW   = 4 * DIGITS;
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    bcd_state_t        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BW-1:0]     work_q, work_d;
    logic              neg_r_q, neg_r_d;
    logic              neg_q, neg_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BW-1:0]     corr_s;
    logic [BW-1:0]     work_sh_s;
    logic [WIDTH-1:0]  mag_sh_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (work_q[4*g +: 4]),
            .q (corr_s[4*g +: 4])
        );
    end

    // Magnitude MSB shifts into the corrected BCD register each step
    assign work_sh_s = {corr_s[BW-2:0], mag_q[WIDTH-1]};
    assign mag_sh_s  = {mag_q[WIDTH-2:0], 1'b0};

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mag_d   = mag_q;
        work_d  = work_q;
        neg_r_d = neg_r_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    neg_r_d = product[WIDTH-1];
                    // 0x8000 negates to itself, which reads as 32768 unsigned
                    mag_d   = product[WIDTH-1] ? (~product + WIDTH'(1)) : product;
                    work_d  = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            CONVERT: begin
                work_d = work_sh_s;
                mag_d  = mag_sh_s;
                if (count_q == LAST) begin
                    count_d = '0;
                    bcd_d   = work_sh_s;
                    neg_d   = neg_r_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mag_q   <= '0;
            work_q  <= '0;
            neg_r_q <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mag_q   <= mag_d;
            work_q  <= work_d;
            neg_r_q <= neg_r_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign neg  = neg_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: latency, sign handling, extremes,
// ignored starts, mid-conversion reset and continuous re-triggering.
module tb_product_bcd_converter;
    import product_bcd_converter_pkg::*;

    localparam int W  = PBC_WIDTH;
    localparam int BW = 4 * PBC_DIGITS;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          start;
    logic [W-1:0]  product;
    logic          busy;
    logic          done;
    logic          neg;
    logic [BW-1:0] bcd;

    int checks = 0;
    int errors = 0;

    product_bcd_converter dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .start   (start),
        .product (product),
        .busy    (busy),
        .done    (done),
        .neg     (neg),
        .bcd     (bcd)
    );

    always #5 CLK = ~CLK;

    // Pulse start for one edge; returns at the negedge after that edge (edge 0)
    task automatic start_conv(input logic [W-1:0] p);
        @(negedge CLK);
        product = p;
        start   = 1'b1;
        @(negedge CLK);
        start   = 1'b0;
    endtask

    // Waits for done; lat = edges after edge 0, -1 on timeout
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (done) begin
                lat = i;
                break;
            end
            busy_cnt += busy ? 1 : 0;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b0; product = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, neg, bcd} !== {3'b000, 20'h00000}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b neg=%b bcd=%h, want 0 0 0 00000",
                     busy, done, neg, bcd);
        end
        Reset = 1'b0;
    endtask

    task automatic test_zero();
        int lat, bc;
        start_conv(16'h0000);
        wait_done(lat, bc);
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL zero_latency: got %0d want 16", lat); end
        checks++;
        if (bcd !== 20'h00000 || neg !== 1'b0) begin
            errors++; $display("FAIL zero_result: got neg=%b bcd=%h want 0 00000", neg, bcd);
        end
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_one_cycle: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_neg_small();
        int lat, bc;
        start_conv(16'hFFEB);
        wait_done(lat, bc);
        checks++;
        if (bcd !== 20'h00021 || neg !== 1'b1) begin
            errors++; $display("FAIL neg21_result: got neg=%b bcd=%h want 1 00021", neg, bcd);
        end
        checks++;
        if (bc !== 16) begin errors++; $display("FAIL busy_width: got %0d want 16", bc); end
    endtask

    task automatic test_extremes();
        int lat, bc;
        start_conv(16'h8000);
        wait_done(lat, bc);
        checks++;
        if (bcd !== 20'h32768 || neg !== 1'b1) begin
            errors++; $display("FAIL min_neg: got neg=%b bcd=%h want 1 32768", neg, bcd);
        end
        start_conv(16'h7FFF);
        wait_done(lat, bc);
        checks++;
        if (bcd !== 20'h32767 || neg !== 1'b0) begin
            errors++; $display("FAIL max_pos: got neg=%b bcd=%h want 0 32767", neg, bcd);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc, held_bad, i;
        start_conv(16'h0051);
        wait_done(lat, bc);
        checks++;
        if (bcd !== 20'h00081 || neg !== 1'b0) begin
            errors++; $display("FAIL pos81: got neg=%b bcd=%h want 0 00081", neg, bcd);
        end
        start_conv(16'hFFFF);
        held_bad = 0;
        lat = -1;
        for (i = 1; i <= 40; i++) begin
            if (i == 4) begin product = 16'h1234; start = 1'b1; end
            if (i == 5) start = 1'b0;
            @(negedge CLK);
            if (done) begin lat = i; break; end
            if (bcd !== 20'h00081 || neg !== 1'b0) held_bad++;
        end
        checks++;
        if (held_bad !== 0) begin errors++; $display("FAIL hold_prev: got %0d bad cycles want 0", held_bad); end
        checks++;
        if (lat !== 16) begin errors++; $display("FAIL busy_start_latency: got %0d want 16", lat); end
        checks++;
        if (bcd !== 20'h00001 || neg !== 1'b1) begin
            errors++; $display("FAIL minus_one: got neg=%b bcd=%h want 1 00001", neg, bcd);
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_not_queued: got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bc, seen;
        start_conv(16'h1234);
        repeat (7) @(negedge CLK);
        Reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, neg, bcd} !== {3'b000, 20'h00000}) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b done=%b neg=%b bcd=%h want 0 0 0 00000",
                     busy, done, neg, bcd);
        end
        @(negedge CLK);
        Reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL no_done_after_abort: got %0d active cycles want 0", seen); end
        start_conv(16'h1234);
        wait_done(lat, bc);
        checks++;
        if (bcd !== 20'h04660 || neg !== 1'b0 || lat !== 16) begin
            errors++; $display("FAIL after_reset_4660: got neg=%b bcd=%h lat=%0d want 0 04660 16", neg, bcd, lat);
        end
    endtask

    task automatic test_back_to_back();
        int prev, pulses, bad_gap, bad_val;
        @(negedge CLK);
        product = 16'hFF00;
        start   = 1'b1;
        prev = -1; pulses = 0; bad_gap = 0; bad_val = 0;
        for (int c = 0; c < 80 && pulses < 3; c++) begin
            @(negedge CLK);
            if (done) begin
                if (bcd !== 20'h00256 || neg !== 1'b1) bad_val++;
                if (prev >= 0 && (c - prev) != 18) bad_gap++;
                prev = c;
                pulses++;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
        checks++;
        if (bad_gap !== 0) begin errors++; $display("FAIL b2b_period: got %0d bad gaps want 0", bad_gap); end
        checks++;
        if (bad_val !== 0) begin errors++; $display("FAIL b2b_value: got %0d bad results want 0", bad_val); end
        repeat (20) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_neg_small();
        test_extremes();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
